// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard / run-control unit.
package pipeline_ctrl_pkg;

    // Debug run-control states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_STEP   = 2'd3
    } state_e;

    // EX operand source selects
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // True when a later stage writes a non-zero register that matches src
    function automatic logic reg_hit(input logic [4:0] src, input logic wen, input logic [4:0] dst);
        return wen && (src != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Purely combinational forwarding selects and hazard stall detection.
module hazard_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [4:0] rs_E,
    input  logic [4:0] rt_E,
    input  logic [4:0] write_reg_E,
    input  logic [4:0] write_reg_M,
    input  logic [4:0] write_reg_W,
    input  logic       reg_write_E,
    input  logic       reg_write_M,
    input  logic       reg_write_W,
    input  logic       mem_to_reg_E,
    input  logic       mem_to_reg_M,
    input  logic       branch_D,
    input  logic       jump_D,
    input  logic       jr_D,
    output logic [1:0] forward_a_E,
    output logic [1:0] forward_b_E,
    output logic       forward_a_D,
    output logic       forward_b_D,
    output logic       hazard_stall
);

    logic lw_stall;
    logic branch_stall;
    logic e_dep;
    logic m_dep;

    // EX operand forwarding; the younger MEM result wins over WB
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        forward_a_E = FWD_REG;
        forward_b_E = FWD_REG;
        if (reg_hit(rs_E, reg_write_M, write_reg_M))
            forward_a_E = FWD_MEM;
        else if (reg_hit(rs_E, reg_write_W, write_reg_W))
            forward_a_E = FWD_WB;
        if (reg_hit(rt_E, reg_write_M, write_reg_M))
            forward_b_E = FWD_MEM;
        else if (reg_hit(rt_E, reg_write_W, write_reg_W))
            forward_b_E = FWD_WB;
    end

    // ID branch comparator operands can only be fed from MEM
    always_comb begin
        forward_a_D = reg_hit(rs_D, reg_write_M, write_reg_M);
        forward_b_D = reg_hit(rt_D, reg_write_M, write_reg_M);
    end

    // Load-use and branch-operand stalls; jr only reads rs, so rt is checked for branches only
    always_comb begin
        lw_stall = mem_to_reg_E && (rt_E != 5'd0) && !jump_D &&
                   ((rt_E == rs_D) || (rt_E == rt_D));
        e_dep = reg_hit(rs_D, reg_write_E, write_reg_E) ||
                (branch_D && reg_hit(rt_D, reg_write_E, write_reg_E));
        m_dep = reg_hit(rs_D, mem_to_reg_M, write_reg_M) ||
                (branch_D && reg_hit(rt_D, mem_to_reg_M, write_reg_M));
        branch_stall = (branch_D || jr_D) && (e_dep || m_dep);
        hazard_stall = lw_stall || branch_stall;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and debug run-control unit for the 5-stage MIPS pipeline.
// Optional performance counters are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter bit START_HALTED = 1'b0,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [4:0]       rs_E,
    input  logic [4:0]       rt_E,
    input  logic [4:0]       write_reg_E,
    input  logic [4:0]       write_reg_M,
    input  logic [4:0]       write_reg_W,
    input  logic             reg_write_E,
    input  logic             reg_write_M,
    input  logic             reg_write_W,
    input  logic             mem_to_reg_E,
    input  logic             mem_to_reg_M,
    input  logic             branch_D,
    input  logic             jump_D,
    input  logic             jr_D,
    input  logic             halt_req,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             cnt_clr,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_E,
    output logic [1:0]       forward_a_E,
    output logic [1:0]       forward_b_E,
    output logic             forward_a_D,
    output logic             forward_b_D,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam state_e RESET_STATE = START_HALTED ? ST_HALTED : ST_RUN;

    state_e state_q;
    state_e state_d;
    logic   hazard_stall;
    logic   ctl_D;
    logic   halt_pending;
    logic   halt_hold;

    hazard_unit u_hazard (
        .rs_D         (rs_D),
        .rt_D         (rt_D),
        .rs_E         (rs_E),
        .rt_E         (rt_E),
        .write_reg_E  (write_reg_E),
        .write_reg_M  (write_reg_M),
        .write_reg_W  (write_reg_W),
        .reg_write_E  (reg_write_E),
        .reg_write_M  (reg_write_M),
        .reg_write_W  (reg_write_W),
        .mem_to_reg_E (mem_to_reg_E),
        .mem_to_reg_M (mem_to_reg_M),
        .branch_D     (branch_D),
        .jump_D       (jump_D),
        .jr_D         (jr_D),
        .forward_a_E  (forward_a_E),
        .forward_b_E  (forward_b_E),
        .forward_a_D  (forward_a_D),
        .forward_b_D  (forward_b_D),
        .hazard_stall (hazard_stall)
    );

    // Run-control state register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignment so all flops update from pre-edge values.
        if (!rst_n) state_q <= RESET_STATE;
        else        state_q <= state_d;
    end

    // Next state; request priority run > halt > step
    always_comb begin
        ctl_D   = branch_D || jump_D || jr_D;
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (halt_req && !run_req) state_d = ctl_D ? ST_DRAIN : ST_HALTED;
            end
            ST_DRAIN: begin
                if (run_req)     state_d = ST_RUN;
                else if (!ctl_D) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (run_req)       state_d = ST_RUN;
                else if (step_req) state_d = ST_STEP;
            end
            ST_STEP: begin
                // The stepped instruction only leaves ID once its hazard clears
                if (run_req)            state_d = ST_RUN;
                else if (!hazard_stall) state_d = ST_DRAIN;
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // Freeze fetch/decode only when no control transfer sits in ID
    always_comb begin
        halt_pending = (state_q == ST_DRAIN) ||
                       ((state_q == ST_RUN) && halt_req && !run_req);
        halt_hold    = (state_q == ST_HALTED) || (halt_pending && !ctl_D);
        stall_F      = hazard_stall || halt_hold;
        stall_D      = stall_F;
        flush_E      = stall_F;
    end

    assign halted = (state_q == ST_HALTED);

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Saturating counters over non-halted cycles; clear wins over increment
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            cycle_cnt_d = '0;
            stall_cnt_d = '0;
        end else if (!halt_hold) begin
            if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
            if (hazard_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: counters are plain flops, not memory, so they take the async reset.
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign cycle_cnt      = '0;
    assign stall_cnt      = '0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Hazard and run-control unit for the 5-stage MIPS pipeline datapath.
- Combinationally generates forwarding selects, load-use and branch-operand stalls, and the EX flush.
- Adds a debug run-control FSM with RUN/DRAIN/HALTED/STEP states. It freezes fetch/decode only when no control transfer sits in ID, so the datapath's internal ID flush cannot lose an instruction.
- Sits beside the datapath and drives its stall_F, stall_D, flush_E and forward_* inputs.

Parameters:
- START_HALTED, 0, 1 = leave reset in HALTED instead of RUN.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rs_D, rt_D, rs_E, rt_E  in  5 each  source register fields, ID/EX
- write_reg_E, write_reg_M, write_reg_W  in  5 each  destination registers
- reg_write_E, reg_write_M, reg_write_W  in  1 each  write enables
- mem_to_reg_E, mem_to_reg_M  in  1 each  load in EX/MEM
- branch_D, jump_D, jr_D  in  1 each  control transfer in ID
- halt_req, run_req, step_req  in  1 each  debug requests, single-cycle pulses
- cnt_clr  in  1  synchronous counter clear
- stall_F, stall_D, flush_E  out  1 each  pipeline control
- forward_a_E, forward_b_E  out  2 each  EX operand select: 00 reg, 01 WB, 10 MEM
- forward_a_D, forward_b_D  out  1 each  ID compare operand from MEM
- halted  out  1  FSM in HALTED
- cycle_cnt, stall_cnt  out  CNT_W each  performance counters

Behaviour:
Forwarding (combinational):
- forward_a_E = 10 if rs_E!=0 & reg_write_M & write_reg_M==rs_E.
- Otherwise forward_a_E = 01 if rs_E!=0 & reg_write_W & write_reg_W==rs_E.
- Otherwise forward_a_E = 00. MEM has priority over WB.
- forward_b_E uses the same rule with rt_E.
- forward_a_D = rs_D!=0 & reg_write_M & write_reg_M==rs_D. forward_b_D is the same with rt_D.

Stalls:
- lw_stall = mem_to_reg_E & rt_E!=0 & ~jump_D & (rt_E==rs_D | rt_E==rt_D).
- Branch stall: (branch_D|jr_D) stalls when either condition holds:
  - reg_write_E & write_reg_E!=0 and write_reg_E matches rs_D, or matches rt_D (rt_D only when branch_D);
  - mem_to_reg_M & write_reg_M!=0 with the same matching rule.
- hazard_stall = lw_stall | branch_stall.

Run control:
- ctl_D = branch_D | jump_D | jr_D.
- halt_pending = state==DRAIN | (state==RUN & halt_req & ~run_req).
- halt_hold = state==HALTED | (halt_pending & ~ctl_D).
- stall_F = stall_D = flush_E = hazard_stall | halt_hold.

FSM (state registered; request priority run_req > halt_req > step_req):
- RUN: halt_req → HALTED if ~ctl_D, else DRAIN.
- DRAIN: ~ctl_D → HALTED (hold already asserted this cycle); run_req → RUN.
- HALTED: run_req → RUN (hold released the next cycle); step_req → STEP; halt_req ignored.
- STEP: no hold. If ~hazard_stall, the ID instruction advances and the next state is DRAIN. If hazard_stall, stay in STEP. run_req → RUN.
- Net effect of one step: one ID instruction issues. Extra instructions issue only while a control transfer occupies ID.

Reset and outputs:
- Reset (asynchronous, any time, including mid-STEP or mid-DRAIN): state = START_HALTED ? HALTED : RUN, counters = 0.
- halted = (state==HALTED), registered.
- With START_HALTED=1, ID holds a reset NOP, so halting from reset is safe.
- All other outputs are combinational with zero latency.

Optional Feature:
- Macro PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments on every cycle with ~halt_hold.
  - stall_cnt increments on cycles with hazard_stall & ~halt_hold.
  - Both counters saturate at all-ones.
  - cnt_clr zeroes both and has priority over increment.
- Undefined: no counter flops; cycle_cnt and stall_cnt tie to 0; cnt_clr is ignored.

Decomposition:
- Package/header pipeline_ctrl_pkg holds:
  - state encoding RUN=0, DRAIN=1, HALTED=2, STEP=3;
  - forward codes FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module hazard_unit holds the purely combinational forwarding and stall logic, with hazard_stall as an output.
- pipeline_ctrl holds the FSM, the hold merge and the counters.

Test Plan:
1. Forwarding: rs_E=8 with reg_write_M, write_reg_M=8 → forward_a_E=10. The same register only in WB → 01. rs_E=0 matching in M → 00.
2. Load-use: mem_to_reg_E=1, rt_E=8, rs_D=8, jump_D=0 → stall_F=stall_D=flush_E=1 for exactly one cycle. The same inputs with jump_D=1 → no stall.
3. Branch: branch_D, rs_D=9, reg_write_E with write_reg_E=9 → stall. Next cycle reg_write_M with write_reg_M=9 and nothing in E → no stall, forward_a_D=1.
4. Halt: halt_req pulse with branch_D=1 → no hold, state DRAIN. Next cycle branch_D=0 → stall_F=1 that cycle, halted=1 on the following cycle.
5. Step: from HALTED, step_req with no hazard → exactly one cycle with stall_F=0, then halted=1 again. If lw_stall is active at that point, the FSM stays in STEP until the stall clears.
6. Counters (macro on): 10 running cycles including 2 hazard stalls → cycle_cnt=10, stall_cnt=2. cnt_clr → both 0. Macro off → both 0.
